// File: rtl/mult_div_iter_if.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_iter_if
// Description : Handshake, control and data bundle of the iterative MDU.
// Revision    : 1.0 - initial release
// ============================================================================
interface mult_div_iter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                      stall_all;
    logic                      flush;
    logic                      start;
    logic [2:0]                op;
    logic [DATA_WIDTH-1:0]     operand_1;
    logic [DATA_WIDTH-1:0]     operand_2;
    logic [DATA_WIDTH-1:0]     hi;
    logic [DATA_WIDTH-1:0]     lo;
    logic                      busy;
    logic                      done;
    logic                      div_zero;
    logic [2*DATA_WIDTH-1:0]   result;

    modport master (
        output stall_all, flush, start, op, operand_1, operand_2, hi, lo,
        input  busy, done, div_zero, result
    );

    modport slave (
        input  stall_all, flush, start, op, operand_1, operand_2, hi, lo,
        output busy, done, div_zero, result
    );
endinterface
`default_nettype wire

// File: rtl/mult_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_iter
// Description : Iterative signed/unsigned multiply/divide, W-cycle CALC phase.
//               Optional HI/LO multiply-accumulate under `MDU_ACCUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_iter #(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mult_div_iter_if.slave   mdu
);
    localparam int                 c_cnt_w    = $clog2(DATA_WIDTH) + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DATA_WIDTH);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_prep = 3'd1;
    localparam logic [2:0] c_st_calc = 3'd2;
    localparam logic [2:0] c_st_fix  = 3'd3;
    localparam logic [2:0] c_st_done = 3'd4;

    logic [2:0]              r_state;
    logic [2:0]              w_state_nxt;
    logic                    w_accept;
    logic                    w_run;

    logic [2:0]              r_op;
    logic [DATA_WIDTH-1:0]   r_op1;
    logic [DATA_WIDTH-1:0]   r_op2;
    logic [DATA_WIDTH-1:0]   r_acc_hi;
    logic [DATA_WIDTH-1:0]   r_acc_lo;
    logic [DATA_WIDTH-1:0]   r_mcand;
    logic                    r_neg_res;
    logic                    r_neg_rem;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [2*DATA_WIDTH-1:0] r_result;
    logic                    r_div_zero;

    logic                    w_is_div;
    logic                    w_is_signed;
    logic                    w_sign1;
    logic                    w_sign2;
    logic [DATA_WIDTH-1:0]   w_abs1;
    logic [DATA_WIDTH-1:0]   w_abs2;
    logic [DATA_WIDTH:0]     w_mul_sum;
    logic [DATA_WIDTH:0]     w_div_sh;
    logic [DATA_WIDTH:0]     w_div_diff;
    logic                    w_div_ge;
    logic [2*DATA_WIDTH-1:0] w_mag;
    logic [2*DATA_WIDTH-1:0] w_prod;
    logic [DATA_WIDTH-1:0]   w_quo;
    logic [DATA_WIDTH-1:0]   w_rem;
    logic [2*DATA_WIDTH-1:0] w_fix_result;
    logic                    w_fix_dz;

`ifdef MDU_ACCUM_EN
    logic [2*DATA_WIDTH-1:0] r_hilo;
`else
    logic                    w_unused_hilo;
    assign w_unused_hilo = ^{mdu.hi, mdu.lo};
`endif

    assign w_run       = !mdu.flush && !mdu.stall_all;
    assign w_is_div    = (r_op[2:1] == 2'b01);
    assign w_is_signed = ~r_op[0];
    assign w_sign1     = w_is_signed & r_op1[DATA_WIDTH-1];
    assign w_sign2     = w_is_signed & r_op2[DATA_WIDTH-1];
    assign w_abs1      = w_sign1 ? -r_op1 : r_op1;
    assign w_abs2      = w_sign2 ? -r_op2 : r_op2;

    // Shift-add step: add multiplicand when multiplier LSB is set, shift pair right.
    assign w_mul_sum  = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_mcand} : '0);
    // Restoring divide step: partial remainder shifted left with next dividend bit.
    assign w_div_sh   = {r_acc_hi, r_acc_lo[DATA_WIDTH-1]};
    assign w_div_diff = w_div_sh - {1'b0, r_mcand};
    assign w_div_ge   = (w_div_sh >= {1'b0, r_mcand});

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            c_st_idle, c_st_done: begin
                if (mdu.start) begin
                    w_state_nxt = c_st_prep;
                    w_accept    = 1'b1;
                end else begin
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_prep: w_state_nxt = c_st_calc;
            c_st_calc: if (r_cnt == c_cnt_last) w_state_nxt = c_st_fix;
            c_st_fix:  w_state_nxt = c_st_done;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else if (mdu.flush) begin
            r_state <= c_st_idle;
        end else if (!mdu.stall_all) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_mag        = {r_acc_hi, r_acc_lo};
        w_prod       = r_neg_res ? -w_mag : w_mag;
        w_quo        = r_neg_res ? -r_acc_lo : r_acc_lo;
        w_rem        = r_neg_rem ? -r_acc_hi : r_acc_hi;
        w_fix_result = w_prod;
        w_fix_dz     = 1'b0;
        if (w_is_div) begin
            // Divide by zero bypasses sign fix-up so DIV and DIVU agree.
            if (r_op2 == '0) begin
                w_fix_result = {r_op1, {DATA_WIDTH{1'b1}}};
                w_fix_dz     = 1'b1;
            end else begin
                w_fix_result = {w_rem, w_quo};
            end
        end
`ifdef MDU_ACCUM_EN
        else if (r_op[2]) begin
            w_fix_result = r_op[1] ? (r_hilo - w_prod) : (r_hilo + w_prod);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op       <= '0;
            r_op1      <= '0;
            r_op2      <= '0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_mcand    <= '0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_cnt      <= '0;
            r_result   <= '0;
            r_div_zero <= 1'b0;
`ifdef MDU_ACCUM_EN
            r_hilo     <= '0;
`endif
        end else if (w_run) begin
            if (w_accept) begin
                r_op  <= mdu.op;
                r_op1 <= mdu.operand_1;
                r_op2 <= mdu.operand_2;
`ifdef MDU_ACCUM_EN
                r_hilo <= {mdu.hi, mdu.lo};
`endif
            end
            case (r_state)
                c_st_prep: begin
                    r_acc_hi  <= '0;
                    r_acc_lo  <= w_abs1;
                    r_mcand   <= w_abs2;
                    r_cnt     <= '0;
                    r_neg_res <= w_sign1 ^ w_sign2;
                    r_neg_rem <= w_sign1;
                end
                c_st_calc: begin
                    if (r_cnt != c_cnt_last) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_is_div) begin
                            r_acc_hi <= w_div_ge ? w_div_diff[DATA_WIDTH-1:0]
                                                 : w_div_sh[DATA_WIDTH-1:0];
                            r_acc_lo <= {r_acc_lo[DATA_WIDTH-2:0], w_div_ge};
                        end else begin
                            r_acc_hi <= w_mul_sum[DATA_WIDTH:1];
                            r_acc_lo <= {w_mul_sum[0], r_acc_lo[DATA_WIDTH-1:1]};
                        end
                    end
                end
                c_st_fix: begin
                    r_result   <= w_fix_result;
                    r_div_zero <= w_fix_dz;
                end
                default: ;
            endcase
        end
    end

    assign mdu.busy     = (r_state == c_st_prep) || (r_state == c_st_calc) ||
                          (r_state == c_st_fix);
    assign mdu.done     = (r_state == c_st_done);
    assign mdu.div_zero = r_div_zero;
    assign mdu.result   = r_result;
endmodule
`default_nettype wire

// File: tb/tb_mult_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_iter
// Description : Directed-vector bench for mult_div_iter (W=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_iter;
    localparam int W = 32;

    localparam logic [2:0] c_mult  = 3'b000;
    localparam logic [2:0] c_multu = 3'b001;
    localparam logic [2:0] c_div   = 3'b010;
    localparam logic [2:0] c_divu  = 3'b011;
    localparam logic [2:0] c_madd  = 3'b100;
    localparam logic [2:0] c_maddu = 3'b101;
    localparam logic [2:0] c_msub  = 3'b110;

`ifdef MDU_ACCUM_EN
    localparam logic [63:0] c_exp_madd  = 64'd17;
    localparam logic [63:0] c_exp_msub  = 64'hFFFFFFFF_FFFFFFF9;
`else
    localparam logic [63:0] c_exp_madd  = 64'd12;
    localparam logic [63:0] c_exp_msub  = 64'd12;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_div_iter_if #(.DATA_WIDTH(W)) mdu ();

    mult_div_iter #(.DATA_WIDTH(W)) u_dut (
        .clk (clk),
        .rst (rst),
        .mdu (mdu.slave)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check_value(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a request for one edge, then scramble inputs to prove they were latched.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] h, input logic [31:0] l);
        @(negedge clk);
        mdu.start     = 1'b1;
        mdu.op        = op;
        mdu.operand_1 = a;
        mdu.operand_2 = b;
        mdu.hi        = h;
        mdu.lo        = l;
        @(posedge clk);
        #1;
        mdu.start     = 1'b0;
        mdu.op        = c_divu;
        mdu.operand_1 = 32'hDEADBEEF;
        mdu.operand_2 = 32'h0;
        mdu.hi        = 32'hA5A5A5A5;
        mdu.lo        = 32'h5A5A5A5A;
    endtask

    task automatic wait_done(input string tag, input int exp_lat, input int stall_at,
                             input int stall_len, input bit poke);
        int lat;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            if (c == stall_at) mdu.stall_all = 1'b1;
            if (c == stall_at + stall_len) mdu.stall_all = 1'b0;
            if (poke) mdu.start = (c == 3);
            @(posedge clk);
            #1;
            if (mdu.done) begin
                lat = c;
                break;
            end
        end
        mdu.stall_all = 1'b0;
        mdu.start     = 1'b0;
        check_value({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] h, input logic [31:0] l,
                       input logic [63:0] exp_res, input logic exp_dz);
        issue(op, a, b, h, l);
        wait_done(tag, 35, 0, 0, 1'b0);
        check_value({tag, "_res"}, mdu.result, exp_res);
        check_value({tag, "_dz"}, 64'(mdu.div_zero), 64'(exp_dz));
    endtask

    initial begin
        bit seen_done;
        rst           = 1'b1;
        mdu.stall_all = 1'b0;
        mdu.flush     = 1'b0;
        mdu.start     = 1'b0;
        mdu.op        = 3'b000;
        mdu.operand_1 = '0;
        mdu.operand_2 = '0;
        mdu.hi        = '0;
        mdu.lo        = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_value("rst_busy", 64'(mdu.busy), 64'd0);
        check_value("rst_done", 64'(mdu.done), 64'd0);
        check_value("rst_dz", 64'(mdu.div_zero), 64'd0);
        check_value("rst_result", mdu.result, 64'd0);

        // First op also pokes start while busy; it must be ignored.
        issue(c_divu, 32'd142, 32'd12, 32'd0, 32'd0);
        check_value("divu_busy", 64'(mdu.busy), 64'd1);
        wait_done("divu", 35, 0, 0, 1'b1);
        check_value("divu_res", mdu.result, 64'h0000000A_0000000B);
        check_value("divu_dz", 64'(mdu.div_zero), 64'd0);
        @(posedge clk);
        #1;
        check_value("done_pulse", 64'(mdu.done), 64'd0);
        check_value("idle_busy", 64'(mdu.busy), 64'd0);

        // Back-to-back: each run issues during the previous op's DONE cycle.
        run("div_neg", c_div, 32'h80000012, 32'h00000012, 0, 0, 64'hFFFFFFFE_F8E38E3A, 1'b0);
        run("mult", c_mult, 32'hFFFFFFFF, 32'd2, 0, 0, 64'hFFFFFFFF_FFFFFFFE, 1'b0);
        run("multu", c_multu, 32'hFFFFFFFF, 32'd2, 0, 0, 64'h00000001_FFFFFFFE, 1'b0);
        run("divu_z", c_divu, 32'd7, 32'd0, 0, 0, 64'h00000007_FFFFFFFF, 1'b1);
        run("div_ovf", c_div, 32'h80000000, 32'hFFFFFFFF, 0, 0, 64'h00000000_80000000, 1'b0);
        run("div_z_neg", c_div, 32'hFFFFFFF9, 32'd0, 0, 0, 64'hFFFFFFF9_FFFFFFFF, 1'b1);
        run("div_m7_2", c_div, 32'hFFFFFFF9, 32'd2, 0, 0, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
        run("div_7_m2", c_div, 32'd7, 32'hFFFFFFFE, 0, 0, 64'h00000001_FFFFFFFD, 1'b0);
        run("mult_nn", c_mult, 32'hFFFFFFFD, 32'hFFFFFFFB, 0, 0, 64'd15, 1'b0);
        run("multu_big", c_multu, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 64'hFFFFFFFE_00000001, 1'b0);

        // Five stalled edges mid-CALC push done out by five cycles.
        issue(c_multu, 32'd3, 32'd4, 0, 0);
        wait_done("stall", 40, 10, 5, 1'b0);
        check_value("stall_res", mdu.result, 64'd12);

        // Flush mid-CALC: cancelled op never completes and result is kept.
        issue(c_multu, 32'd5, 32'd5, 0, 0);
        repeat (8) @(posedge clk);
        #1;
        check_value("pre_flush_busy", 64'(mdu.busy), 64'd1);
        mdu.flush = 1'b1;
        @(posedge clk);
        #1;
        mdu.flush = 1'b0;
        check_value("flush_busy", 64'(mdu.busy), 64'd0);
        seen_done = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            if (mdu.done) seen_done = 1'b1;
        end
        check_value("flush_no_done", 64'(seen_done), 64'd0);
        check_value("flush_res", mdu.result, 64'd12);

        run("after_flush", c_multu, 32'd6, 32'd7, 0, 0, 64'd42, 1'b0);
        run("madd", c_madd, 32'd3, 32'd4, 32'd0, 32'd5, c_exp_madd, 1'b0);
        run("msub", c_msub, 32'd3, 32'd4, 32'd0, 32'd5, c_exp_msub, 1'b0);
        run("maddu", c_maddu, 32'd3, 32'd4, 32'd0, 32'd5, c_exp_madd, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mult_div_iter.md
# mult_div_iter

Parametrised iterative multiply/divide unit for the CPU execute stage, the successor to the fixed 32-bit MultDiv. Runs signed/unsigned multiply and divide over DATA_WIDTH bits with a start/busy/done handshake, pipeline stall and flush, defined divide-by-zero behaviour, and optional HI/LO multiply-accumulate. The result is written into the HI/LO register pair by the writeback logic.

## Interface
- DATA_WIDTH, 32: operand width W; result is 2W bits; W must be even and ≥ 4.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- stall_all  in  1  global pipeline stall; freezes all state.
- flush  in  1  cancels any operation in flight.
- start  in  1  request; accepted only when busy=0.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU.
- operand_1  in  W  multiplicand or dividend.
- operand_2  in  W  multiplier or divisor.
- hi, lo  in  W each  current HI/LO values, used by the accumulate ops.
- busy  out  1  high in PREP, CALC and FIX.
- done  out  1  one-cycle pulse; result is valid from this cycle on.
- div_zero  out  1  qualified by done; the completed divide had divisor 0.
- result  out  2W  {hi, lo}. Multiply: the product. Divide: {remainder, quotient}.

## Operation
- FSM states: IDLE → PREP → CALC → FIX → DONE → IDLE.
- IDLE/DONE + start (no stall, no flush):
  - latch op, operands, hi and lo;
  - go to PREP.
  - Start is accepted in DONE too, so back-to-back operations work.
- PREP: for signed ops, take absolute values and record the result sign and the remainder sign.
- CALC: runs exactly W iterations on a log2(W)+1-bit counter.
  - Multiply: radix-2 shift-add.
  - Divide: restoring shift-subtract.
- FIX:
  - apply sign fix-up: product sign = XOR of the operand signs; quotient truncates toward zero; remainder takes the dividend's sign;
  - apply accumulate (when compiled in);
  - register result and div_zero.
- DONE: done=1 for one cycle, then IDLE unless a new start is accepted.
- Divide by zero: quotient = all ones, remainder = operand_1, div_zero=1.
  - Sign fix-up is bypassed, so this holds for DIV and DIVU alike.
  - Latency is unchanged.
- Signed overflow (most-negative ÷ −1): quotient = most-negative value, remainder = 0.
- Arithmetic wraps modulo 2^(2W); no overflow flag.
- result holds its value until the next FIX. It is not cleared on IDLE or on flush.

## Timing
- Reset: state=IDLE; busy=0, done=0, div_zero=0; result=0; all internal registers 0.
- Priority each edge: rst > flush > stall_all > normal.
- Latency: with start sampled at edge k, done is high in the cycle following edge k+W+3 (k+35 for W=32), assuming no stall.
- stall_all=1: no register changes, including the CALC counter. Each stalled cycle adds exactly one cycle of latency. A start sampled during a stall is ignored.
- flush=1:
  - next state IDLE, busy=0;
  - no done for the cancelled operation;
  - result and div_zero unchanged;
  - a simultaneous start is ignored.
- A flush in DONE suppresses nothing already visible: done was already high in that cycle.
- start while busy=1: ignored. The latched operands are unaffected by later input changes.

## Configuration
- MDU_ACCUM_EN defined:
  - MADD/MADDU: result = {hi,lo} + product.
  - MSUB/MSUBU: result = {hi,lo} − product.
  - Signedness of the product follows the op; the sum wraps mod 2^(2W).
- MDU_ACCUM_EN undefined:
  - ops 100–111 execute as MULT (100, 110) or MULTU (101, 111);
  - hi/lo are ignored;
  - no accumulator adder is synthesised.

## Test plan
- DIVU 142 ÷ 12, W=32 → done at edge k+35; result {hi=0x0000000A, lo=0x0000000B}; div_zero=0.
- DIV 0x80000012 ÷ 0x00000012 → {hi=0xFFFFFFFE, lo=0xF8E38E3A}.
- MULT 0xFFFFFFFF × 2 → 0xFFFFFFFF_FFFFFFFE. MULTU with the same operands → 0x00000001_FFFFFFFE.
- DIVU 7 ÷ 0 → {hi=0x00000007, lo=0xFFFFFFFF}; div_zero=1. DIV 0x80000000 ÷ 0xFFFFFFFF → {hi=0, lo=0x80000000}.
- MULTU 3 × 4 with stall_all held 5 cycles mid-CALC → done 5 cycles late, result 12. Repeat with flush mid-CALC → busy=0 next cycle, no done, result keeps its previous value.
- Accumulate with hi=0, lo=5, operands 3 and 4:
  - MDU_ACCUM_EN defined: MADD → 17; MSUB → 0xFFFFFFFF_FFFFFFF9.
  - MDU_ACCUM_EN undefined: MADD → 12.
